control_mc: RTL and testbench

Multi-cycle instruction control unit for the pako32 RV32I core. It sequences each instruction through fetch, execute, optional memory access and write-back, and handles fetch and data-memory handshakes. It decodes the full RV32I base set except FENCE/SYSTEM and drives the register file, ALU operand muxes and PC update. It sits between instruction/data memory ports and the datapath (regfile, ALU, PC register), replacing the single-cycle LUI/AUIPC-only controller.

---
 rtl/control_mc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_control_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_mc.sv
// control_mc: multi-cycle RV32I control unit for the pako32 core.
// Optional illegal-opcode trap is enabled by defining CONTROL_ILLEGAL_TRAP_EN.
module control_mc #(
    parameter int unsigned RESET_WAIT = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_ack_i,
    input  logic             br_cond_i,
    output logic             wr_en_o,
    output logic [4:0]       rd_idx_o,
    output logic [4:0]       rs1_idx_o,
    output logic [4:0]       rs2_idx_o,
    output logic [31:0]      imm_data_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             alu_a_sel_o,
    output logic             alu_b_sel_o,
    output logic [1:0]       reg_sel_o,
    output logic             pc_en_o,
    output logic [1:0]       pc_next_sel_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);
    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_SLL   = 4'd2;
    localparam logic [3:0] ALU_OP_SLT   = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd4;
    localparam logic [3:0] ALU_OP_XOR   = 4'd5;
    localparam logic [3:0] ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] ALU_OP_OR    = 4'd8;
    localparam logic [3:0] ALU_OP_AND   = 4'd9;
    localparam logic [3:0] ALU_OP_PASSB = 4'd10;

    localparam logic ALU_A_SEL_RS1 = 1'b0;
    localparam logic ALU_A_SEL_PC  = 1'b1;
    localparam logic ALU_B_SEL_RS2 = 1'b0;
    localparam logic ALU_B_SEL_IMM = 1'b1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu, f3_alu;
    logic        dec_asel, dec_bsel;
    logic [1:0]  dec_rsel;
    logic        dec_known, dec_wr, dec_jump, dec_br, dec_mem, dec_store;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    always_comb begin
        unique case (ir_q[14:12])
            3'b000:  f3_alu = ALU_OP_ADD;
            3'b001:  f3_alu = ALU_OP_SLL;
            3'b010:  f3_alu = ALU_OP_SLT;
            3'b011:  f3_alu = ALU_OP_SLTU;
            3'b100:  f3_alu = ALU_OP_XOR;
            3'b101:  f3_alu = ir_q[30] ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  f3_alu = ALU_OP_OR;
            default: f3_alu = ALU_OP_AND;
        endcase
    end

    always_comb begin
        dec_imm   = '0;
        dec_alu   = ALU_OP_ADD;
        dec_asel  = ALU_A_SEL_RS1;
        dec_bsel  = ALU_B_SEL_IMM;
        dec_rsel  = 2'd0;
        dec_known = 1'b1;
        dec_wr    = 1'b0;
        dec_jump  = 1'b0;
        dec_br    = 1'b0;
        dec_mem   = 1'b0;
        dec_store = 1'b0;
        case (ir_q[6:0])
            OPC_LUI: begin
                dec_imm = imm_u;
                dec_alu = ALU_OP_PASSB;
                dec_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm  = imm_u;
                dec_asel = ALU_A_SEL_PC;
                dec_wr   = 1'b1;
            end
            OPC_JAL: begin
                dec_imm  = imm_j;
                dec_asel = ALU_A_SEL_PC;
                dec_rsel = 2'd2;
                dec_wr   = 1'b1;
                dec_jump = 1'b1;
            end
            OPC_JALR: begin
                dec_imm  = imm_i;
                dec_rsel = 2'd2;
                dec_wr   = 1'b1;
                dec_jump = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm  = imm_b;
                dec_asel = ALU_A_SEL_PC;
                dec_br   = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm  = imm_i;
                dec_rsel = 2'd1;
                dec_mem  = 1'b1;
            end
            OPC_STORE: begin
                dec_imm   = imm_s;
                dec_mem   = 1'b1;
                dec_store = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm = imm_i;
                dec_alu = f3_alu;
                dec_wr  = 1'b1;
            end
            OPC_OP: begin
                dec_bsel = ALU_B_SEL_RS2;
                dec_alu  = (ir_q[14:12] == 3'b000 && ir_q[30])
                           ? ALU_OP_SUB : f3_alu;
                dec_wr   = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
    end

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) illegal_q <= 1'b0;
        else         illegal_q <= illegal_d;
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        cnt_d         = '0;
        instret_d     = instret_q;
        imem_req_o    = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        wr_en_o       = 1'b0;
        pc_en_o       = 1'b0;
        pc_next_sel_o = 2'd0;
        rd_idx_o      = '0;
        rs1_idx_o     = '0;
        rs2_idx_o     = '0;
        imm_data_o    = '0;
        alu_ctrl_o    = ALU_OP_ADD;
        alu_a_sel_o   = ALU_A_SEL_RS1;
        alu_b_sel_o   = ALU_B_SEL_RS2;
        reg_sel_o     = 2'd0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        // Datapath fields stay decoded while the address/result is in flight.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            rd_idx_o    = ir_q[11:7];
            rs1_idx_o   = ir_q[19:15];
            rs2_idx_o   = ir_q[24:20];
            imm_data_o  = dec_imm;
            alu_ctrl_o  = dec_alu;
            alu_a_sel_o = dec_asel;
            alu_b_sel_o = dec_bsel;
            reg_sel_o   = dec_rsel;
        end
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RESET_WAIT - 1) state_d = ST_FETCH;
                else                         cnt_d   = cnt_q + 32'd1;
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!dec_known) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
`else
                    pc_en_o = 1'b1;
                    state_d = ST_FETCH;
`endif
                end else if (dec_mem) begin
                    state_d = ST_MEM;
                end else begin
                    pc_en_o       = 1'b1;
                    wr_en_o       = dec_wr && (ir_q[11:7] != 5'd0);
                    pc_next_sel_o = (dec_jump || (dec_br && br_cond_i))
                                    ? 2'd1 : 2'd0;
                    state_d       = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = dec_store;
                if (dmem_ack_i) begin
                    if (dec_store) begin
                        pc_en_o = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                wr_en_o = ir_q[11:7] != 5'd0;
                pc_en_o = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase
        if (pc_en_o) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_RESET;
            ir_q      <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc (RESET_WAIT=3, CNT_W=4).
// Table of single-cycle instructions plus load/store/illegal/reset sequences.
module tb_control_mc;
    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req, imem_ack;
    logic [31:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        br_cond;
    logic        wr_en, pc_en, illegal;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] imm;
    logic [3:0]  alu_ctrl;
    logic        a_sel, b_sel;
    logic [1:0]  reg_sel, pc_sel;
    logic [3:0]  instret;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    control_mc #(.RESET_WAIT(3), .CNT_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .imem_req_o(imem_req), .imem_ack_i(imem_ack),
        .imem_data_i(imem_data),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_ack_i(dmem_ack), .br_cond_i(br_cond),
        .wr_en_o(wr_en), .rd_idx_o(rd_idx),
        .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
        .imm_data_o(imm), .alu_ctrl_o(alu_ctrl),
        .alu_a_sel_o(a_sel), .alu_b_sel_o(b_sel),
        .reg_sel_o(reg_sel), .pc_en_o(pc_en),
        .pc_next_sel_o(pc_sel), .illegal_o(illegal),
        .instret_o(instret)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        br;
        logic        wr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        asel;
        logic        bsel;
        logic [1:0]  rsel;
        logic [1:0]  psel;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [9:0] ctl_now();
        return {alu_ctrl, a_sel, b_sel, reg_sel, pc_sel};
    endfunction

    task automatic fetch(input logic [31:0] ins);
        int n = 0;
        @(negedge clk); #1;
        while (!imem_req && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("instret", 32'(instret), 32'(exp_ret % 16));
        imem_data = ins;
        imem_ack  = 1'b1;
        @(posedge clk); #1;
        imem_ack  = 1'b0;
        imem_data = '0;
    endtask

    initial begin
        vecs[0] = '{32'h123452B7, 1'b0, 1'b1, 5'd5, 5'd8, 5'd3,
                    32'h12345000, 4'd10, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[1] = '{32'hFFF10093, 1'b0, 1'b1, 5'd1, 5'd2, 5'd31,
                    32'hFFFFFFFF, 4'd0, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[2] = '{32'h402081B3, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2,
                    32'h0, 4'd1, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[3] = '{32'h40325213, 1'b0, 1'b1, 5'd4, 5'd4, 5'd3,
                    32'h403, 4'd7, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[4] = '{32'h00001397, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0,
                    32'h1000, 4'd0, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[5] = '{32'h008000EF, 1'b0, 1'b1, 5'd1, 5'd0, 5'd8,
                    32'h8, 4'd0, 1'b1, 1'b1, 2'd2, 2'd1};
        vecs[6] = '{32'h00008067, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0,
                    32'h0, 4'd0, 1'b0, 1'b1, 2'd2, 2'd1};
        vecs[7] = '{32'h00208863, 1'b1, 1'b0, 5'd16, 5'd1, 5'd2,
                    32'h10, 4'd0, 1'b1, 1'b1, 2'd0, 2'd1};
        vecs[8] = '{32'h00208863, 1'b0, 1'b0, 5'd16, 5'd1, 5'd2,
                    32'h10, 4'd0, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[9] = '{32'h00100013, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1,
                    32'h1, 4'd0, 1'b0, 1'b1, 2'd0, 2'd0};

        rstn = 1'b0; imem_ack = 1'b0; imem_data = '0;
        dmem_ack = 1'b0; br_cond = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_strobes", {30'd0, wr_en, pc_en}, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_ctl", 32'(ctl_now()), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            check("rst_wait_req", 32'(imem_req), (i == 3) ? 32'd1 : 32'd0);
            check("rst_wait_pc_en", 32'(pc_en), 32'd0);
        end

        foreach (vecs[i]) begin
            fetch(vecs[i].instr);
            br_cond = vecs[i].br;
            @(negedge clk); #1;
            check("vec_wr", 32'(wr_en), 32'(vecs[i].wr));
            check("vec_rd", 32'(rd_idx), 32'(vecs[i].rd));
            check("vec_rs1", 32'(rs1_idx), 32'(vecs[i].rs1));
            check("vec_rs2", 32'(rs2_idx), 32'(vecs[i].rs2));
            check("vec_imm", imm, vecs[i].imm);
            check("vec_ctl", 32'(ctl_now()),
                  32'({vecs[i].alu, vecs[i].asel, vecs[i].bsel,
                       vecs[i].rsel, vecs[i].psel}));
            check("vec_pc_en", 32'(pc_en), 32'd1);
            exp_ret++;
            @(posedge clk); #1;
            br_cond = 1'b0;
        end

        // LW x3,8(x2) with ack on the third memory cycle
        fetch(32'h00812183);
        @(negedge clk); #1;
        check("lw_exec_pc_en", 32'(pc_en), 32'd0);
        check("lw_exec_dmem", 32'(dmem_req), 32'd0);
        check("lw_exec_imm", imm, 32'd8);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) dmem_ack = 1'b1;
            #1;
            check("lw_mem_req", 32'(dmem_req), 32'd1);
            check("lw_mem_we", 32'(dmem_we), 32'd0);
            check("lw_mem_strobes", {30'd0, wr_en, pc_en}, 32'd0);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        check("lw_wb_wr", 32'(wr_en), 32'd1);
        check("lw_wb_rsel", 32'(reg_sel), 32'd1);
        check("lw_wb_rd", 32'(rd_idx), 32'd3);
        check("lw_wb_pc_en", 32'(pc_en), 32'd1);
        check("lw_wb_dmem", 32'(dmem_req), 32'd0);
        exp_ret++;

        // SW x4,12(x2) with zero-wait ack
        fetch(32'h00412623);
        @(negedge clk); #1;
        check("sw_exec_pc_en", 32'(pc_en), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        check("sw_mem_req", 32'(dmem_req), 32'd1);
        check("sw_mem_we", 32'(dmem_we), 32'd1);
        check("sw_pc_en", 32'(pc_en), 32'd1);
        check("sw_wr", 32'(wr_en), 32'd0);
        check("sw_imm", imm, 32'd12);
        check("sw_rs2", 32'(rs2_idx), 32'd4);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        exp_ret++;

        // ADDI x0,x0,1 repeated so the 4-bit counter wraps
        for (int k = 0; k < 6; k++) begin
            fetch(32'h00100013);
            @(negedge clk); #1;
            check("nop_wr", 32'(wr_en), 32'd0);
            check("nop_pc_en", 32'(pc_en), 32'd1);
            exp_ret++;
        end

        fetch(32'h0000007F);
        @(negedge clk); #1;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        begin
            bit seen = 1'b0;
            check("ill_pc_en", 32'(pc_en), 32'd0);
            check("ill_wr", 32'(wr_en), 32'd0);
            @(negedge clk); #1;
            check("ill_flag", 32'(illegal), 32'd1);
            repeat (6) begin
                @(negedge clk); #1;
                if (imem_req || pc_en || wr_en) seen = 1'b1;
            end
            check("ill_trap_quiet", 32'(seen), 32'd0);
            check("ill_instret", 32'(instret), 32'(exp_ret % 16));
        end
`else
        check("ill_pc_en", 32'(pc_en), 32'd1);
        check("ill_wr", 32'(wr_en), 32'd0);
        check("ill_flag", 32'(illegal), 32'd0);
        exp_ret++;
        fetch(32'h00100013);
        @(negedge clk); #1;
        check("ill_next_pc_en", 32'(pc_en), 32'd1);
`endif

        // Reset pulse, then abort a pending fetch asynchronously
        rstn = 1'b0;
        @(negedge clk); #1;
        check("rst2_illegal", 32'(illegal), 32'd0);
        check("rst2_instret", 32'(instret), 32'd0);
        rstn = 1'b1;
        begin
            int n = 0;
            while (!imem_req && n < 10) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check("abort_pre_req", 32'(imem_req), 32'd1);
        rstn = 1'b0;
        #1;
        check("abort_req_drop", 32'(imem_req), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
